// File: rtl/stream_max_argmax_if.sv
// Stream bundle for stream_max_argmax.
// Input side : in_valid/in_ready/in_data, LANES signed elements per beat, lane 0 in the low bits.
// Output side: out_valid/out_ready/out_max/out_index, the signed maximum of the vector and
//              the element index where it first occurs.
// Modports   : slave  - the reduction block (consumes beats, produces the result)
//              master - the producer/consumer environment around it
interface stream_max_argmax_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 2,
  parameter int IDX_WIDTH  = 3
);

  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_WIDTH*LANES-1:0] in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_WIDTH-1:0]       out_max;
  logic [IDX_WIDTH-1:0]        out_index;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    output out_valid,
    input  out_ready,
    output out_max,
    output out_index
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    input  out_valid,
    output out_ready,
    input  out_max,
    input  out_index
  );

endinterface

// File: rtl/stream_max_argmax.sv
// Streaming signed max/argmax over a DATA_LENGTH-element vector delivered LANES elements per
// beat. The result is held on the output handshake until consumed.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous reset, active-high
//   bus - stream_max_argmax_if.slave
//         in_valid/in_ready/in_data    : input beats
//         out_valid/out_ready          : result handshake
//         out_max/out_index            : registered maximum and its element index
// Ties keep the lowest index, both across lanes of a beat and across beats.
module stream_max_argmax #(
  parameter int DATA_WIDTH  = 16,
  parameter int DATA_LENGTH = 8,
  parameter int LANES       = 2,
  parameter int IDX_WIDTH   = 3
) (
  input logic                clk,
  input logic                rst,
  stream_max_argmax_if.slave bus
);

  localparam int BEATS = DATA_LENGTH / LANES;
  localparam int CNT_W = $clog2(BEATS + 1);

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } state_e;

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0] max_q, max_d;
  logic [IDX_WIDTH-1:0]         idx_q, idx_d;

  // Beat winner from the lane reduction
  logic signed [DATA_WIDTH-1:0] lane_max;
  logic [IDX_WIDTH-1:0]         lane_sel;
  logic [IDX_WIDTH-1:0]         beat_base;
  logic [IDX_WIDTH-1:0]         lane_idx;

  // Lane reduction: strict greater-than so the lowest lane wins a tie.
  always_comb begin
    lane_max = $signed(bus.in_data[DATA_WIDTH-1:0]);
    lane_sel = '0;
    for (int j = 1; j < LANES; j++) begin
      if ($signed(bus.in_data[DATA_WIDTH*j +: DATA_WIDTH]) > lane_max) begin
        lane_max = $signed(bus.in_data[DATA_WIDTH*j +: DATA_WIDTH]);
        lane_sel = IDX_WIDTH'(j);
      end
    end
  end

  // Counter is 0 in StIdle, so the first beat's base index is 0 without a special case.
  always_comb begin
    beat_base = IDX_WIDTH'(cnt_q) * IDX_WIDTH'(LANES);
    lane_idx  = beat_base + lane_sel;
  end

  // Next-state logic. The handshake outputs are decoded from state_q only, so in_valid is
  // simply ignored in StDone and out_ready has no path to in_ready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    idx_d   = idx_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          // First beat loads unconditionally; there is nothing to compare against yet.
          max_d = lane_max;
          idx_d = lane_idx;
          if (BEATS == 1) begin
            state_d = StDone;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = StAccum;
          end
        end
      end

      StAccum: begin
        if (bus.in_valid) begin
          // Strictly greater: an equal later value keeps the earlier, lower index.
          if (lane_max > max_q) begin
            max_d = lane_max;
            idx_d = lane_idx;
          end
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      max_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    bus.in_ready  = (state_q != StDone);
    bus.out_valid = (state_q == StDone);
    bus.out_max   = max_q;
    bus.out_index = idx_q;
  end

endmodule

// File: tb/tb_stream_max_argmax.sv
// Self-checking bench for stream_max_argmax: a 16/8/2 instance for the main scenarios and a
// LANES=1, DATA_LENGTH=4 instance. Expected results come from a linear-scan reference model
// and are queued when a vector is driven, then popped when the DUT presents a result.
module tb_stream_max_argmax;

  typedef struct {
    logic [15:0] mx;
    logic [2:0]  idx;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   passed;
  int   cyc;
  exp_t sb[$];

  stream_max_argmax_if #(.DATA_WIDTH(16), .LANES(2), .IDX_WIDTH(3)) bus ();
  stream_max_argmax_if #(.DATA_WIDTH(16), .LANES(1), .IDX_WIDTH(2)) bus1 ();

  stream_max_argmax #(
    .DATA_WIDTH (16),
    .DATA_LENGTH(8),
    .LANES      (2),
    .IDX_WIDTH  (3)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  stream_max_argmax #(
    .DATA_WIDTH (16),
    .DATA_LENGTH(4),
    .LANES      (1),
    .IDX_WIDTH  (2)
  ) u_dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: first occurrence of the largest value in element order.
  function automatic exp_t model(input int v[8], input int len);
    exp_t e;
    int   best;
    int   bi;
    best = v[0];
    bi   = 0;
    for (int i = 1; i < len; i++) begin
      if (v[i] > best) begin
        best = v[i];
        bi   = i;
      end
    end
    e.mx  = 16'(best);
    e.idx = 3'(bi);
    return e;
  endfunction

  function automatic logic [31:0] pk(input int a, input int b);
    return {16'(b), 16'(a)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and wait until it is taken (in_ready seen high before an edge).
  task automatic send_beat(input logic [31:0] d);
    bit rdy;
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    do begin
      rdy = bus.in_ready;
      step();
      n++;
    end while (!rdy && n < 50);
    if (!rdy) begin
      total++;
      $display("FAIL beat_accept: in_ready=0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic send_vector(input int v[8], input bit gaps);
    sb.push_back(model(v, 8));
    for (int b = 0; b < 4; b++) begin
      send_beat(pk(v[2*b], v[2*b+1]));
      if (gaps && b < 3) begin
        bus.in_valid = 1'b0;
        step();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b required 0", bus.out_valid);
    else passed++;
    total++;
    if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b required 1", bus.in_ready);
    else passed++;
    total++;
    if (bus.out_max !== 16'd0) $display("FAIL rst_out_max: got %h required 0000", bus.out_max);
    else passed++;
    total++;
    if (bus.out_index !== 3'd0) $display("FAIL rst_out_index: got %0d required 0", bus.out_index);
    else passed++;
    total++;
    if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1)
      $display("FAIL rst_lanes1: got valid=%b ready=%b required 0/1", bus1.out_valid, bus1.in_ready);
    else passed++;
    rst = 1'b0;
    step();
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL post_rst: got ready=%b valid=%b required 1/0", bus.in_ready, bus.out_valid);
    else passed++;
  endtask

  // Shared flow for a single vector with out_ready high: result the cycle after the last beat.
  task automatic run_single(input string name, input int v[8]);
    exp_t e;
    bus.out_ready = 1'b1;
    send_vector(v, 1'b0);
    total++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
      $display("FAIL %s_done: got valid=%b ready=%b required 1/0", name, bus.out_valid,
               bus.in_ready);
    else passed++;
    e = sb.pop_front();
    total++;
    if (bus.out_max !== e.mx) $display("FAIL %s_max: got %h required %h", name, bus.out_max, e.mx);
    else passed++;
    total++;
    if (bus.out_index !== e.idx)
      $display("FAIL %s_index: got %0d required %0d", name, bus.out_index, e.idx);
    else passed++;
    bus.in_valid = 1'b0;
    step();
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL %s_release: got valid=%b ready=%b required 0/1", name, bus.out_valid,
               bus.in_ready);
    else passed++;
  endtask

  task automatic test_basic();
    int v[8] = '{3, -5, 7, 2, -1, 7, 0, 4};
    run_single("basic", v);
  endtask

  task automatic test_negative();
    int v[8] = '{-9, -3, -4, -8, -3, -100, -32768, -32767};
    run_single("negative", v);
  endtask

  task automatic test_backpressure();
    int   v[8] = '{3, -5, 7, 2, -1, 7, 0, 4};
    exp_t e;
    bus.out_ready = 1'b0;
    send_vector(v, 1'b1);
    e = sb.pop_front();
    // Keep offering a beat during the hold; it must not be consumed.
    bus.in_valid = 1'b1;
    bus.in_data  = pk(32767, 32767);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
        $display("FAIL hold_hs[%0d]: got valid=%b ready=%b required 1/0", i, bus.out_valid,
                 bus.in_ready);
      else passed++;
      total++;
      if (bus.out_max !== e.mx || bus.out_index !== e.idx)
        $display("FAIL hold_result[%0d]: got %h/%0d required %h/%0d", i, bus.out_max,
                 bus.out_index, e.mx, e.idx);
      else passed++;
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL bp_release: got valid=%b ready=%b required 0/1", bus.out_valid, bus.in_ready);
    else passed++;
    total++;
    if (bus.out_max !== e.mx || bus.out_index !== e.idx)
      $display("FAIL bp_retain: got %h/%0d required %h/%0d", bus.out_max, bus.out_index, e.mx,
               e.idx);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int v1[8] = '{3, -5, 7, 2, -1, 7, 0, 4};
    int v2[8] = '{0, 1, 2, 3, 4, 5, 6, 32767};
    int   nres;
    int   t[2];
    bit   prev_ov;
    exp_t e;
    nres    = 0;
    prev_ov = 1'b0;
    bus.out_ready = 1'b1;
    fork
      begin
        send_vector(v1, 1'b0);
        send_vector(v2, 1'b0);
        bus.in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 16; i++) begin
          step();
          if (bus.out_valid === 1'b1) begin
            total++;
            if (prev_ov) $display("FAIL b2b_pulse: got out_valid high 2 cycles, required 1");
            else passed++;
            if (nres < 2) t[nres] = cyc;
            nres++;
            if (sb.size() == 0) begin
              total++;
              $display("FAIL b2b_extra: got unexpected result %h, required none", bus.out_max);
            end else begin
              e = sb.pop_front();
              total++;
              if (bus.out_max !== e.mx || bus.out_index !== e.idx)
                $display("FAIL b2b_result: got %h/%0d required %h/%0d", bus.out_max,
                         bus.out_index, e.mx, e.idx);
              else passed++;
            end
          end
          prev_ov = bus.out_valid;
        end
      end
    join
    total++;
    if (nres != 2) $display("FAIL b2b_count: got %0d results required 2", nres);
    else passed++;
    if (nres == 2) begin
      total++;
      if (t[1] - t[0] != 5) $display("FAIL b2b_period: got %0d cycles required 5", t[1] - t[0]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int v[8] = '{1, 1, 1, 1, 1, 1, 1, 1};
    bus.out_ready = 1'b1;
    send_beat(pk(500, 600));
    send_beat(pk(700, 800));
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL midrst_hs: got valid=%b ready=%b required 0/1", bus.out_valid, bus.in_ready);
    else passed++;
    total++;
    if (bus.out_max !== 16'd0) $display("FAIL midrst_max: got %h required 0000", bus.out_max);
    else passed++;
    run_single("after_rst", v);
  endtask

  task automatic test_lanes1();
    int   v[8] = '{5, 9, 9, -2, 0, 0, 0, 0};
    exp_t e;
    bit   rdy;
    int   n;
    e = model(v, 4);
    bus1.out_ready = 1'b1;
    bus1.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus1.in_data = 16'(v[i]);
      if (i == 3) begin
        total++;
        if (bus1.out_valid !== 1'b0)
          $display("FAIL l1_early: got out_valid=%b before last beat, required 0", bus1.out_valid);
        else passed++;
      end
      n = 0;
      do begin
        rdy = bus1.in_ready;
        step();
        n++;
      end while (!rdy && n < 50);
      if (!rdy) begin
        total++;
        $display("FAIL l1_accept: in_ready=0 for %0d cycles, required 1", n);
      end
    end
    bus1.in_valid = 1'b0;
    total++;
    if (bus1.out_valid !== 1'b1) $display("FAIL l1_valid: got %b required 1", bus1.out_valid);
    else passed++;
    total++;
    if (bus1.out_max !== e.mx || bus1.out_index !== e.idx[1:0])
      $display("FAIL l1_result: got %h/%0d required %h/%0d", bus1.out_max, bus1.out_index, e.mx,
               e.idx[1:0]);
    else passed++;
    step();
    total++;
    if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1)
      $display("FAIL l1_release: got valid=%b ready=%b required 0/1", bus1.out_valid,
               bus1.in_ready);
    else passed++;
  endtask

  initial begin
    total          = 0;
    passed         = 0;
    rst            = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = '0;
    bus1.out_ready = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_negative();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_lanes1();
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left, required 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
